// File: rtl/pause_pkg.sv
// Shared types and defaults for the core pause sequencer.
package pause_pkg;

  typedef enum logic [1:0] {
    PS_RUN      = 2'd0,
    PS_WAIT_VBL = 2'd1,
    PS_HALT     = 2'd2
  } pause_state_t;

  // ~10 s of user pause at 18 MHz before the screen dims
  localparam logic [31:0] DIM_CYCLES_DEF  = 32'h0ABA9500;
  // Fallback when no video is running: force the halt after this many cycles
  localparam logic [19:0] VBL_TIMEOUT_DEF = 20'd400000;

endpackage

// File: rtl/pause_dim_timer.sv
// Screen-dim timer: counts halted cycles during a user pause, saturating at
// DIM_CYCLES, and raises dim_video once the threshold is reached.
module pause_dim_timer
  import pause_pkg::*;
#(
  parameter logic [31:0] DIM_CYCLES = DIM_CYCLES_DEF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic user_paused,
  input  logic halted,
  output logic dim_video
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: cleared outside a user pause, saturating increment while halted
  always_comb begin
    cnt_d = cnt_q;
    if (!user_paused) begin
      cnt_d = '0;
    end else if (halted && (cnt_q < DIM_CYCLES)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter and registered compare; the compare uses the next count so the
  // flag drops together with the cleared timer.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q     <= '0;
      dim_video <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dim_video <= user_paused & (cnt_d >= DIM_CYCLES);
    end
  end

endmodule

// File: rtl/pause_sequencer.sv
// Core pause sequencer: merges pause sources, aligns pause entry to a VBlank
// rising edge (with a timeout fallback), grants hiscore RAM access only while
// halted, and optionally dims the screen after a long user pause.
// Optional feature macro: PAUSE_DIM_EN (dim timer and dim_video).
module pause_sequencer
  import pause_pkg::*;
#(
  parameter logic [31:0] DIM_CYCLES  = DIM_CYCLES_DEF,
  parameter logic [19:0] VBL_TIMEOUT = VBL_TIMEOUT_DEF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic vblank,
  input  logic btn_pause,
  input  logic osd_open,
  input  logic osd_pause_en,
  input  logic hs_req,
  output logic hs_grant,
  output logic pause,
  output logic user_paused,
  output logic dim_video
);

  pause_state_t state_q;
  pause_state_t state_d;
  logic         btn_prev;
  logic         vbl_prev;
  logic [19:0]  vbl_cnt;
  logic         want;
  logic         vbl_rise;
  logic         vbl_expired;
  logic         hold_halt;

  assign want        = user_paused | (osd_open & osd_pause_en) | hs_req;
  assign vbl_rise    = vblank & ~vbl_prev;
  assign vbl_expired = (vbl_cnt == (VBL_TIMEOUT - 20'd1));
  // Staying halted through this edge; both outputs derive from it so
  // pause and hs_grant drop on the same edge at resume.
  assign hold_halt   = (state_q == PS_HALT) && (state_d == PS_HALT);

  // Next-state logic; cancellation wins over an edge in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PS_RUN: begin
        if (want) state_d = PS_WAIT_VBL;
      end
      PS_WAIT_VBL: begin
        if (!want)                        state_d = PS_RUN;
        else if (vbl_rise || vbl_expired) state_d = PS_HALT;
      end
      PS_HALT: begin
        if (!want) state_d = PS_RUN;
      end
      default: state_d = PS_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= PS_RUN;
    else       state_q <= state_d;
  end

  // Button/VBlank edge registers and the user pause toggle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_prev    <= 1'b0;
      vbl_prev    <= 1'b0;
      user_paused <= 1'b0;
    end else begin
      btn_prev <= btn_pause;
      vbl_prev <= vblank;
      if (btn_pause && !btn_prev) user_paused <= ~user_paused;
    end
  end

  // VBlank timeout counter, held at zero outside WAIT_VBL
  always_ff @(posedge clk_sys) begin
    if (reset || (state_q != PS_WAIT_VBL)) vbl_cnt <= '0;
    else                                   vbl_cnt <= vbl_cnt + 20'd1;
  end

  // Registered pause and hiscore grant
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pause    <= 1'b0;
      hs_grant <= 1'b0;
    end else begin
      pause    <= hold_halt;
      hs_grant <= hold_halt & hs_req;
    end
  end

`ifdef PAUSE_DIM_EN
  pause_dim_timer #(
    .DIM_CYCLES(DIM_CYCLES)
  ) u_dim_timer (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .user_paused(user_paused),
    .halted     (state_q == PS_HALT),
    .dim_video  (dim_video)
  );
`else
  logic dim_cycles_unused;
  assign dim_cycles_unused = ^DIM_CYCLES;
  assign dim_video         = 1'b0;
`endif

endmodule
